// File: rtl/div_if.sv
// Execute-stage <-> divider handshake: start is accepted only while busy is low;
// valid is a one-cycle strobe and y holds the last result until the next completion.
interface div_if #(
   parameter int XLEN = 32
);
   logic            start;
   logic [1:0]      op;
   logic            is_word_op;
   logic [XLEN-1:0] d0;
   logic [XLEN-1:0] d1;
   logic            flush;
   logic            busy;
   logic            valid;
   logic [XLEN-1:0] y;

   modport master (output start, op, is_word_op, d0, d1, flush, input busy, valid, y);
   modport slave  (input start, op, is_word_op, d0, d1, flush, output busy, valid, y);
endinterface

// File: rtl/div_unit.sv
// Iterative radix-2 restoring divider for RV32M/RV64M DIV/DIVU/REM/REMU (+ word forms).
// Define DIV_FAST_SPECIAL_EN to bypass CALC for divide-by-zero and signed overflow.
module div_unit #(
   parameter int XLEN = 32
) (
   input  logic       clk,
   input  logic       reset,
   div_if.slave       bus,
   output logic [1:0] dbg_state
);
   localparam int CW = $clog2(XLEN + 1);

   typedef enum logic [1:0] {IDLE, PREP, CALC, DONE} state_t;

   state_t          state_q, state_d;
   logic [1:0]      op_q, op_d;
   logic            word_q, word_d;
   logic [XLEN-1:0] a_q, a_d, b_q, b_d;
   logic [XLEN-1:0] rem_q, rem_d, quo_q, quo_d, div_q, div_d;
   logic [XLEN-1:0] y_q, y_d;
   logic [CW-1:0]   cnt_q, cnt_d;
   logic            qneg_q, qneg_d, rneg_q, rneg_d;
   logic            dbz_q, dbz_d, ovf_q, ovf_d;
   logic            valid_q, valid_d;

   logic            is_signed, pre_dbz, pre_ovf;
   logic [XLEN-1:0] a_ext, b_ext, min_neg, abs_a, abs_b, rem_n, quo_n;
   logic [CW-1:0]   n_iter;
   logic [XLEN:0]   r_sh, diff;

   function automatic logic [XLEN-1:0] ext32(input logic [XLEN-1:0] v, input logic sgn);
      logic [XLEN-1:0] t;
      t       = {XLEN{sgn & v[31]}};
      t[31:0] = v[31:0];
      return t;
   endfunction

   // Special cases are resolved from flags so both the bypass and the full CALC run agree.
   function automatic logic [XLEN-1:0] result(input logic [1:0] op, input logic word,
                                              input logic qneg, input logic rneg,
                                              input logic dbz, input logic ovf,
                                              input logic [XLEN-1:0] a,
                                              input logic [XLEN-1:0] quo,
                                              input logic [XLEN-1:0] rem);
      logic [XLEN-1:0] q, r, s;
      q = dbz ? {XLEN{1'b1}} : (ovf ? a : (qneg ? -quo : quo));
      r = dbz ? a : (ovf ? {XLEN{1'b0}} : (rneg ? -rem : rem));
      s = op[1] ? r : q;
      return word ? ext32(s, 1'b1) : s;
   endfunction

   always_comb begin
      is_signed = ~op_q[0];
      a_ext     = word_q ? ext32(a_q, is_signed) : a_q;
      b_ext     = word_q ? ext32(b_q, is_signed) : b_q;
      min_neg   = word_q ? ext32(XLEN'(32'h8000_0000), 1'b1) : {1'b1, {(XLEN-1){1'b0}}};
      abs_a     = (is_signed && a_ext[XLEN-1]) ? -a_ext : a_ext;
      abs_b     = (is_signed && b_ext[XLEN-1]) ? -b_ext : b_ext;
      n_iter    = word_q ? CW'(32) : CW'(XLEN);
      pre_dbz   = (b_ext == '0);
      pre_ovf   = is_signed && (b_ext == '1) && (a_ext == min_neg);
      // Extra top bit keeps the compare exact when the divisor exceeds 2^(XLEN-1).
      r_sh      = {rem_q, quo_q[XLEN-1]};
      diff      = r_sh - {1'b0, div_q};
      rem_n     = diff[XLEN] ? r_sh[XLEN-1:0] : diff[XLEN-1:0];
      quo_n     = {quo_q[XLEN-2:0], ~diff[XLEN]};
   end

   always_comb begin
      state_d = state_q;
      op_d    = op_q;
      word_d  = word_q;
      a_d     = a_q;
      b_d     = b_q;
      rem_d   = rem_q;
      quo_d   = quo_q;
      div_d   = div_q;
      cnt_d   = cnt_q;
      qneg_d  = qneg_q;
      rneg_d  = rneg_q;
      dbz_d   = dbz_q;
      ovf_d   = ovf_q;
      y_d     = y_q;
      valid_d = 1'b0;
      case (state_q)
         IDLE: begin
            if (bus.start) begin
               state_d = PREP;
               op_d    = bus.op;
               word_d  = bus.is_word_op && (XLEN == 64);
               a_d     = bus.d0;
               b_d     = bus.d1;
            end
         end
         PREP: begin
            a_d    = a_ext;
            qneg_d = is_signed & (a_ext[XLEN-1] ^ b_ext[XLEN-1]);
            rneg_d = is_signed & a_ext[XLEN-1];
            dbz_d  = pre_dbz;
            ovf_d  = pre_ovf;
            rem_d  = '0;
            // Word dividends are pre-aligned to the top so N shifts consume exactly 32 bits.
            quo_d  = word_q ? (abs_a << (XLEN - 32)) : abs_a;
            div_d  = abs_b;
            cnt_d  = n_iter;
            state_d = CALC;
`ifdef DIV_FAST_SPECIAL_EN
            if (pre_dbz || pre_ovf) begin
               state_d = DONE;
               valid_d = 1'b1;
               y_d     = result(op_q, word_q, 1'b0, 1'b0, pre_dbz, pre_ovf, a_ext, '0, '0);
            end
`endif
         end
         CALC: begin
            rem_d = rem_n;
            quo_d = quo_n;
            cnt_d = cnt_q - 1'b1;
            // Result is fixed up and registered on the edge entering DONE, so valid/y
            // are both visible for the whole DONE cycle.
            if (cnt_q == CW'(1)) begin
               state_d = DONE;
               valid_d = 1'b1;
               y_d     = result(op_q, word_q, qneg_q, rneg_q, dbz_q, ovf_q, a_q, quo_n, rem_n);
            end
         end
         DONE:    state_d = IDLE;
         default: state_d = IDLE;
      endcase
      if (bus.flush && (state_q != IDLE)) begin
         state_d = IDLE;
         valid_d = 1'b0;
         y_d     = y_q;
      end
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_q <= IDLE;
         op_q    <= '0;
         word_q  <= 1'b0;
         a_q     <= '0;
         b_q     <= '0;
         rem_q   <= '0;
         quo_q   <= '0;
         div_q   <= '0;
         cnt_q   <= '0;
         qneg_q  <= 1'b0;
         rneg_q  <= 1'b0;
         dbz_q   <= 1'b0;
         ovf_q   <= 1'b0;
         y_q     <= '0;
         valid_q <= 1'b0;
      end else begin
         state_q <= state_d;
         op_q    <= op_d;
         word_q  <= word_d;
         a_q     <= a_d;
         b_q     <= b_d;
         rem_q   <= rem_d;
         quo_q   <= quo_d;
         div_q   <= div_d;
         cnt_q   <= cnt_d;
         qneg_q  <= qneg_d;
         rneg_q  <= rneg_d;
         dbz_q   <= dbz_d;
         ovf_q   <= ovf_d;
         y_q     <= y_d;
         valid_q <= valid_d;
      end
   end

   assign bus.busy  = (state_q != IDLE);
   assign bus.valid = valid_q;
   assign bus.y     = y_q;
   assign dbg_state = state_q;
endmodule

// File: tb/tb_div_unit.sv
// Self-checking bench for div_unit: one XLEN=32 and one XLEN=64 instance.
// Honours DIV_FAST_SPECIAL_EN for the expected latency of special cases.
module tb_div_unit;
   logic clk = 1'b0;
   logic reset;
   always #5 clk = ~clk;

   div_if #(.XLEN(32)) bus32 ();
   div_if #(.XLEN(64)) bus64 ();
   logic [1:0] dbg32, dbg64;

   div_unit #(.XLEN(32)) u_dut32 (.clk(clk), .reset(reset), .bus(bus32), .dbg_state(dbg32));
   div_unit #(.XLEN(64)) u_dut64 (.clk(clk), .reset(reset), .bus(bus64), .dbg_state(dbg64));

`ifdef DIV_FAST_SPECIAL_EN
   localparam int SPEC_LAT = 1;
`else
   localparam int SPEC_LAT = 33;
`endif

   int checks = 0;
   int errors = 0;
   logic [63:0] exp_q[$];
   logic [31:0] last_y32 = '0;

   initial begin
      #2_000_000;
      $display("FAIL timeout: simulation exceeded time limit");
      $fatal(1);
   end

   function automatic logic [31:0] ref32(input logic [1:0] op, input logic [31:0] a, input logic [31:0] b);
      logic [31:0] q, r;
      if (b == 32'd0) begin
         q = '1;
         r = a;
      end else if (!op[0] && a == 32'h8000_0000 && b == 32'hFFFF_FFFF) begin
         q = a;
         r = '0;
      end else if (!op[0]) begin
         q = $signed(a) / $signed(b);
         r = $signed(a) % $signed(b);
      end else begin
         q = a / b;
         r = a % b;
      end
      return op[1] ? r : q;
   endfunction

   task automatic drive_start(input bit w64, input logic [1:0] op, input bit word,
                              input logic [63:0] a, input logic [63:0] b);
      if (w64) begin
         bus64.start = 1'b1; bus64.op = op; bus64.is_word_op = word; bus64.d0 = a; bus64.d1 = b;
      end else begin
         bus32.start = 1'b1; bus32.op = op; bus32.is_word_op = word; bus32.d0 = a[31:0]; bus32.d1 = b[31:0];
      end
   endtask

   // Issues one op, pushes its expected result, then watches lat+3 cycles.
   // poke_at > 0 pulses start with junk operands so it is sampled at edge E(poke_at).
   task automatic run_op(input bit w64, input logic [1:0] op, input bit word,
                         input logic [63:0] a, input logic [63:0] b, input logic [63:0] exp,
                         input int lat, input int poke_at, input string name);
      int nvalid, first;
      logic v, bz;
      logic [63:0] got, want;
      exp_q.push_back(exp);
      @(negedge clk);
      drive_start(w64, op, word, a, b);
      @(posedge clk); #1;
      bus32.start = 1'b0; bus64.start = 1'b0;
      nvalid = 0; first = -1;
      for (int k = 1; k <= lat + 3; k++) begin
         if (k == poke_at) drive_start(w64, 2'b01, 1'b0, 64'h1234, 64'h3);
         @(posedge clk); #1;
         bus32.start = 1'b0; bus64.start = 1'b0;
         v   = w64 ? bus64.valid : bus32.valid;
         bz  = w64 ? bus64.busy : bus32.busy;
         got = w64 ? bus64.y : {32'b0, bus32.y};
         if (k == 1) begin
            checks++;
            if (bz !== 1'b1) begin errors++; $display("FAIL %s busy_after_E1: got %b want 1", name, bz); end
         end
         if (k == lat + 1) begin
            checks++;
            if (bz !== 1'b0) begin errors++; $display("FAIL %s busy_after_done: got %b want 0", name, bz); end
         end
         if (v === 1'b1) begin
            nvalid++;
            if (first < 0) first = k;
            checks++;
            if (exp_q.size() == 0) begin
               errors++; $display("FAIL %s unexpected_valid at E%0d", name, k);
            end else begin
               want = exp_q.pop_front();
               if (got !== want) begin errors++; $display("FAIL %s result: got %h want %h", name, got, want); end
            end
         end
      end
      checks++;
      if (first != lat) begin errors++; $display("FAIL %s latency: got E%0d want E%0d", name, first, lat); end
      checks++;
      if (nvalid != 1) begin errors++; $display("FAIL %s valid_count: got %0d want 1", name, nvalid); end
      exp_q.delete();
      if (!w64) last_y32 = exp[31:0];
   endtask

   task automatic test_reset;
      reset = 1'b1;
      repeat (3) @(posedge clk);
      #1;
      checks++; if (bus32.busy !== 1'b0) begin errors++; $display("FAIL reset_busy32: got %b want 0", bus32.busy); end
      checks++; if (bus32.valid !== 1'b0) begin errors++; $display("FAIL reset_valid32: got %b want 0", bus32.valid); end
      checks++; if (bus32.y !== 32'h0) begin errors++; $display("FAIL reset_y32: got %h want 0", bus32.y); end
      checks++; if (bus64.busy !== 1'b0) begin errors++; $display("FAIL reset_busy64: got %b want 0", bus64.busy); end
      checks++; if (bus64.y !== 64'h0) begin errors++; $display("FAIL reset_y64: got %h want 0", bus64.y); end
      @(negedge clk);
      reset = 1'b0;
   endtask

   task automatic test_signed;
      run_op(1'b0, 2'b00, 1'b0, 64'hFFFF_FFF9, 64'h2, 64'hFFFF_FFFD, 33, 0, "div_neg7_2");
      run_op(1'b0, 2'b10, 1'b0, 64'hFFFF_FFF9, 64'h2, 64'hFFFF_FFFF, 33, 0, "rem_neg7_2");
   endtask

   task automatic test_unsigned_busy_start;
      run_op(1'b0, 2'b01, 1'b0, 64'hFFFF_FFFF, 64'h10, 64'h0FFF_FFFF, 33, 5, "divu_poke_calc");
      run_op(1'b0, 2'b11, 1'b0, 64'hFFFF_FFFF, 64'h10, 64'h0000_000F, 33, 34, "remu_poke_done");
   endtask

   task automatic test_div_zero;
      run_op(1'b0, 2'b00, 1'b0, 64'h5, 64'h0, 64'hFFFF_FFFF, SPEC_LAT, 0, "div_by_zero");
      run_op(1'b0, 2'b10, 1'b0, 64'h5, 64'h0, 64'h5, SPEC_LAT, 0, "rem_by_zero");
      run_op(1'b0, 2'b01, 1'b0, 64'h5, 64'h0, 64'hFFFF_FFFF, SPEC_LAT, 0, "divu_by_zero");
      run_op(1'b0, 2'b11, 1'b0, 64'hFFFF_FFFB, 64'h0, 64'hFFFF_FFFB, SPEC_LAT, 0, "remu_by_zero");
   endtask

   task automatic test_overflow;
      run_op(1'b0, 2'b00, 1'b0, 64'h8000_0000, 64'hFFFF_FFFF, 64'h8000_0000, SPEC_LAT, 0, "div_ovf");
      run_op(1'b0, 2'b10, 1'b0, 64'h8000_0000, 64'hFFFF_FFFF, 64'h0, SPEC_LAT, 0, "rem_ovf");
   endtask

   task automatic test_random;
      logic [31:0] a, b;
      logic [1:0] op;
      int lat;
      for (int i = 0; i < 8; i++) begin
         a  = $urandom();
         b  = (i % 2 == 0) ? 32'($urandom_range(1, 1000)) : $urandom();
         if (i == 3) b = -32'd3;
         op = 2'($urandom_range(0, 3));
         lat = (b == 0 || (!op[0] && a == 32'h8000_0000 && b == 32'hFFFF_FFFF)) ? SPEC_LAT : 33;
         run_op(1'b0, op, 1'b0, {32'b0, a}, {32'b0, b}, {32'b0, ref32(op, a, b)}, lat, 0, "random");
      end
   endtask

   task automatic test_flush;
      int nvalid;
      logic [31:0] prev;
      run_op(1'b0, 2'b01, 1'b0, 64'd1000, 64'd7, 64'd142, 33, 0, "divu_before_flush");
      prev = last_y32;
      nvalid = 0;
      @(negedge clk);
      drive_start(1'b0, 2'b01, 1'b0, 64'd999, 64'd3);
      @(posedge clk); #1;
      bus32.start = 1'b0;
      for (int k = 1; k <= 11; k++) begin
         @(posedge clk); #1;
         if (bus32.valid === 1'b1) nvalid++;
         if (k == 10) begin
            checks++;
            if (bus32.busy !== 1'b1) begin errors++; $display("FAIL flush_busy_E10: got %b want 1", bus32.busy); end
            bus32.flush = 1'b1;
         end
      end
      bus32.flush = 1'b0;
      checks++; if (bus32.busy !== 1'b0) begin errors++; $display("FAIL flush_busy_E11: got %b want 0", bus32.busy); end
      checks++; if (nvalid != 0) begin errors++; $display("FAIL flush_valid: got %0d strobes want 0", nvalid); end
      checks++; if (bus32.y !== prev) begin errors++; $display("FAIL flush_y_hold: got %h want %h", bus32.y, prev); end
      run_op(1'b0, 2'b00, 1'b0, 64'd100, 64'hFFFF_FFF9, 64'hFFFF_FFF2, 33, 0, "div_after_flush");
   endtask

   task automatic test_reset_mid;
      @(negedge clk);
      drive_start(1'b0, 2'b01, 1'b0, 64'd5000, 64'd9);
      @(posedge clk); #1;
      bus32.start = 1'b0;
      repeat (8) @(posedge clk);
      #3;
      reset = 1'b1;
      #1;
      checks++; if (bus32.busy !== 1'b0) begin errors++; $display("FAIL async_reset_busy: got %b want 0", bus32.busy); end
      checks++; if (bus32.valid !== 1'b0) begin errors++; $display("FAIL async_reset_valid: got %b want 0", bus32.valid); end
      checks++; if (bus32.y !== 32'h0) begin errors++; $display("FAIL async_reset_y: got %h want 0", bus32.y); end
      @(negedge clk);
      reset = 1'b0;
      last_y32 = '0;
   endtask

   task automatic test_xlen64;
      run_op(1'b1, 2'b00, 1'b1, 64'h0000_0000_FFFF_FFF9, 64'h2, 64'hFFFF_FFFF_FFFF_FFFD, 33, 0, "divw");
      run_op(1'b1, 2'b01, 1'b0, 64'h0000_0000_FFFF_FFF9, 64'h2, 64'h0000_0000_7FFF_FFFC, 65, 0, "divu64");
      run_op(1'b1, 2'b11, 1'b1, 64'h0000_0000_FFFF_FFF9, 64'h0, 64'hFFFF_FFFF_FFFF_FFF9, SPEC_LAT, 0, "remuw_by_zero");
      run_op(1'b1, 2'b00, 1'b0, 64'hFFFF_FFFF_FFFF_FF9C, 64'd7, 64'hFFFF_FFFF_FFFF_FFF2, 65, 0, "div64_neg");
   endtask

   initial begin
      bus32.start = 1'b0; bus32.op = '0; bus32.is_word_op = 1'b0; bus32.d0 = '0; bus32.d1 = '0; bus32.flush = 1'b0;
      bus64.start = 1'b0; bus64.op = '0; bus64.is_word_op = 1'b0; bus64.d0 = '0; bus64.d1 = '0; bus64.flush = 1'b0;
      test_reset();
      test_signed();
      test_unsigned_busy_start();
      test_div_zero();
      test_overflow();
      test_random();
      test_flush();
      test_reset_mid();
      test_xlen64();
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end
endmodule

// File: doc/div_unit.md
# div_unit

Iterative radix-2 integer divider for the RV32M/RV64M DIV, DIVU, REM and REMU operations, including the word forms when XLEN=64. It sits beside the single-cycle ALU in the execute stage. The execute stage issues one operation with a start pulse, stalls while `busy` is high, and takes the result on a one-cycle `valid` pulse. Results follow RISC-V semantics for divide-by-zero and signed overflow.

## Interface
- `XLEN`, 32: datapath width, 32 or 64.
- `clk` in 1: single clock, rising edge.
- `reset` in 1: asynchronous, active-high reset.
- `start` in 1: request; accepted only when `busy`=0.
- `op` in 2: 00 DIV, 01 DIVU, 10 REM, 11 REMU.
- `is_word_op` in 1: 32-bit word op (DIVW/…); ignored (treated as 0) when XLEN=32.
- `d0` in XLEN: dividend, sampled on the accepting edge.
- `d1` in XLEN: divisor, sampled on the accepting edge.
- `flush` in 1: synchronous abort of any in-flight operation.
- `busy` out 1: high from the accepting edge until return to IDLE.
- `valid` out 1: one-cycle result strobe.
- `y` out XLEN: result, registered, held until the next completion.

## Operation
- States: IDLE, PREP, CALC, DONE.
- IDLE: `start`=1 latches `op`, `is_word_op`, `d0`, `d1` and moves to PREP.
- PREP:
  - N = (is_word_op && XLEN=64) ? 32 : XLEN.
  - Word op: operands are the low 32 bits, sign-extended for DIV/REM and zero-extended for DIVU/REMU.
  - Signed ops: take the absolute values; record the quotient sign (d0 sign XOR d1 sign) and the remainder sign (d0 sign).
  - Load the iteration counter with N. Next state is CALC, except special cases when the macro is defined (see Configuration).
- CALC, one restoring step per cycle:
  - Shift {rem, quo} left by 1.
  - If rem ≥ divisor: rem -= divisor and quo[0] = 1.
  - Decrement the counter; at 0, go to DONE.
- DONE:
  - Apply sign fixups; select quo (DIV/DIVU) or rem (REM/REMU).
  - Word op: sign-extend bit 31 to XLEN (DIVUW/REMUW included).
  - Register into `y`, assert `valid` for exactly this cycle, go to IDLE.
- Required results:
  - Divide-by-zero: quotient all-ones; remainder = dividend (word-extended).
  - Signed overflow (most-negative / −1): quotient = dividend; remainder = 0.
- `start` while `busy`=1 is ignored; this includes the DONE cycle, so there is no back-to-back issue.
- `flush`=1 in PREP, CALC or DONE: next edge goes to IDLE. `valid` is not asserted that edge, `y` is unchanged, `busy` falls. `flush` in IDLE has no effect; `flush` has priority over `start`.
- `reset` asserted at any time: immediately IDLE, `busy`=0, `valid`=0, `y`=0, all internal registers cleared.

## Timing
- Accepting edge is E0.
- PREP occupies E0→E1; CALC covers E1→E(N+1); DONE spans E(N+1)→E(N+2).
- Normal path: `valid`=1 between E(N+1) and E(N+2).
  - XLEN=32: sampled high at edge E33.
  - Word op: sampled high at edge E33.
  - XLEN=64 full-width: sampled high at edge E65.
- `busy`: high after E0, low after E(N+2); that is, low in the first IDLE cycle.
- Fast special path (macro defined): PREP→DONE at E1; `valid` high between E1 and E2; `busy` low after E2.
- Reset values: `busy`=0, `valid`=0, `y`=0.

## Configuration
- Macro: `DIV_FAST_SPECIAL_EN`.
- Defined: PREP detects a zero divisor or signed overflow and jumps straight to DONE with the required result. Latency is 2 edges to IDLE.
- Undefined: no bypass. Special cases run the full N-cycle CALC, and DONE fixups must still produce identical results, with normal-path latency.

## Test plan
- XLEN=32, DIV d0=0xFFFFFFF9 (−7), d1=2: `y`=0xFFFFFFFD; `valid` sampled at E33. REM on the same operands: `y`=0xFFFFFFFF.
- DIVU d0=0xFFFFFFFF, d1=0x10: `y`=0x0FFFFFFF. REMU: `y`=0x0000000F. `start` pulsed during `busy` is ignored, giving a single `valid`.
- Divide-by-zero, d0=5, d1=0:
  - DIV → 0xFFFFFFFF; REM → 0x5; DIVU → 0xFFFFFFFF.
  - `valid` at E1 with `DIV_FAST_SPECIAL_EN`, at E33 without.
- Overflow, DIV d0=0x80000000, d1=0xFFFFFFFF: `y`=0x80000000. REM: `y`=0. Latency per macro, as above.
- Abort and reset:
  - `flush` at E10 → `busy`=0 after E11; no `valid`; `y` keeps its prior value.
  - A new `start` at E12 completes normally.
  - `reset` asserted mid-CALC → `busy`/`valid`/`y` go to 0 without waiting for a clock edge.
- XLEN=64, DIVW d0=0x00000000_FFFFFFF9, d1=2: `y`=0xFFFFFFFF_FFFFFFFD, `valid` at E33. A full-width DIVU of the same operands gives `y`=0x00000000_7FFFFFFC, `valid` at E65.
